// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: state encodings, widths and PC helpers.
package fetch_ctrl_pkg;

  localparam int              INSTR_W  = 32;
  localparam logic [31:0]     PC_STEP  = 32'd4;
  localparam logic [31:0]     PC_RESET = 32'h0000_0000;

  typedef enum logic [2:0] {
    FC_IDLE  = 3'd0,
    FC_RUN   = 3'd1,
    FC_STALL = 3'd2,
    FC_HALT  = 3'd3,
    FC_LOAD  = 3'd4
  } fc_state_e;

  // Fetch addresses are word aligned; low byte-offset bits of a target are dropped.
  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] addr);
    return addr & ~(PC_STEP - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_valid_pipe.sv
// Two-stage valid tracker for the IM-output and IF->ID slots.
// Clear beats hold; a held edge keeps both bits.
module fetch_valid_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       clear,
  input  logic       din,
  output logic [1:0] vld
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= 2'b00;
    end else if (clear) begin
      vld <= 2'b00;
    end else if (!hold) begin
      vld <= {vld[0], din};
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the fetch PC, drives the IM read port, applies stalls,
// redirects and halt, and lends the IM port to the loader while idle or halted.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [INSTR_W-1:0] br_target,
  input  logic               halt,
  input  logic               ld_req,
  output logic               ld_gnt,
  output logic [INSTR_W-1:0] im_addr,
  output logic               im_re,
  output logic [INSTR_W-1:0] pc,
  output logic               flush,
  output logic               if_hold,
  output logic               if_valid,
  output logic               halted
);

  fc_state_e          state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic               flush_q;
  logic               redirect;
  logic               pipe_hold;
  logic               pipe_clear;
  logic [1:0]         vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FC_IDLE;
      pc_q    <= PC_RESET;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= redirect;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect   = 1'b0;
    pipe_hold  = 1'b0;
    pipe_clear = flush_q;
    im_re      = 1'b0;
    if_hold    = 1'b0;
    halted     = 1'b0;
    ld_gnt     = 1'b0;
    case (state_q)
      FC_IDLE: begin
        if (ld_req)   state_d = FC_LOAD;
        else if (run) state_d = FC_RUN;
      end
      FC_RUN: begin
        im_re = 1'b1;
        if (br_taken) begin
          redirect = 1'b1;
          pc_d     = align_pc(br_target);
        end else if (halt) begin
          state_d    = FC_HALT;
          pipe_clear = 1'b1;
        end else if (stall) begin
          // The fetch issued this cycle is dropped and re-issued after the
          // stall, so its valid mark must not enter the pipe.
          state_d   = FC_STALL;
          pipe_hold = 1'b1;
        end else begin
          pc_d = pc_q + PC_STEP;
        end
      end
      FC_STALL: begin
        if_hold   = 1'b1;
        pipe_hold = 1'b1;
        if (br_taken) begin
          redirect = 1'b1;
          pc_d     = align_pc(br_target);
          state_d  = FC_RUN;
        end else if (!stall) begin
          state_d = FC_RUN;
        end
      end
      FC_HALT: begin
        halted = 1'b1;
        if (ld_req) state_d = FC_LOAD;
      end
      FC_LOAD: begin
        ld_gnt = 1'b1;
        if (!ld_req) begin
          state_d = FC_IDLE;
          pc_d    = PC_RESET;
        end
      end
      default: state_d = FC_IDLE;
    endcase
  end

  fetch_valid_pipe u_valid_pipe (
    .clk   (clk),
    .reset (reset),
    .hold  (pipe_hold),
    .clear (pipe_clear),
    .din   (im_re & ~br_taken),
    .vld   (vld)
  );

  assign pc       = pc_q;
  assign im_addr  = pc_q;
  assign flush    = flush_q;
  assign if_valid = vld[1];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one task per scenario, inline comparisons.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt;
  logic        ld_req;
  logic        ld_gnt;
  logic [31:0] im_addr;
  logic        im_re;
  logic [31:0] pc;
  logic        flush;
  logic        if_hold;
  logic        if_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .halt      (halt),
    .ld_req    (ld_req),
    .ld_gnt    (ld_gnt),
    .im_addr   (im_addr),
    .im_re     (im_re),
    .pc        (pc),
    .flush     (flush),
    .if_hold   (if_hold),
    .if_valid  (if_valid),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; stall = 1'b0; br_taken = 1'b0;
    br_target = 32'h0; halt = 1'b0; ld_req = 1'b0;
    #2;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    checks++; if (im_re !== 1'b0) begin errors++; $display("FAIL reset_im_re: got %b want 0", im_re); end
    checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL reset_ld_gnt: got %b want 0", ld_gnt); end
    checks++; if ({flush, if_hold, if_valid, halted} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: got %b want 0000", {flush, if_hold, if_valid, halted}); end
    #10;
    reset = 1'b1;
    step();
    checks++; if (im_re !== 1'b0) begin errors++; $display("FAIL idle_no_fetch: got %b want 0", im_re); end
  endtask

  task automatic test_run();
    run = 1'b1;
    step();
    run = 1'b0;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL run_pc0: got %h want 0", pc); end
    checks++; if (im_re !== 1'b1) begin errors++; $display("FAIL run_im_re: got %b want 1", im_re); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL run_valid0: got %b want 0", if_valid); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL run_pc[%0d]: got %h want %h", i, pc, 32'(4 * i)); end
      checks++; if (im_addr !== 32'(4 * i)) begin errors++; $display("FAIL run_im_addr[%0d]: got %h want %h", i, im_addr, 32'(4 * i)); end
      checks++; if (if_valid !== (i >= 2)) begin errors++; $display("FAIL run_valid[%0d]: got %b want %b", i, if_valid, (i >= 2)); end
    end
  endtask

  task automatic test_branch();
    br_taken = 1'b1; br_target = 32'h0000_0103;
    step();
    br_taken = 1'b0;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL br_pc: got %h want 100", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush: got %b want 1", flush); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_flush_pulse: got %b want 0", flush); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_bubble1: got %b want 0", if_valid); end
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL br_pc1: got %h want 104", pc); end
    step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_bubble2: got %b want 0", if_valid); end
    step();
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL br_target_valid: got %b want 1", if_valid); end
    checks++; if (pc !== 32'h10C) begin errors++; $display("FAIL br_pc3: got %h want 10c", pc); end
  endtask

  task automatic test_stall();
    br_taken = 1'b1; br_target = 32'h10;
    step();
    br_taken = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL stall_setup_pc: got %h want 20", pc); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h20) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 20", i, pc); end
      checks++; if (im_re !== 1'b0) begin errors++; $display("FAIL stall_im_re[%0d]: got %b want 0", i, im_re); end
      checks++; if (if_hold !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %b want 1", i, if_hold); end
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_held[%0d]: got %b want 1", i, if_valid); end
    end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL stall_reissue_pc: got %h want 20", pc); end
    checks++; if (im_re !== 1'b1 || if_hold !== 1'b0)
      begin errors++; $display("FAIL stall_release: got im_re=%b if_hold=%b want 1 0", im_re, if_hold); end
    step();
    checks++; if (pc !== 32'h24) begin errors++; $display("FAIL stall_resume_pc: got %h want 24", pc); end
  endtask

  task automatic test_branch_stall();
    stall = 1'b1;
    step();
    checks++; if (if_hold !== 1'b1) begin errors++; $display("FAIL bs_enter_stall: got %b want 1", if_hold); end
    br_taken = 1'b1; br_target = 32'h200;
    step();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL bs_stall_pc: got %h want 200", pc); end
    checks++; if (im_re !== 1'b1 || if_hold !== 1'b0 || flush !== 1'b1)
      begin errors++; $display("FAIL bs_stall_state: got im_re=%b if_hold=%b flush=%b want 1 0 1", im_re, if_hold, flush); end
    br_target = 32'h300;
    step();
    checks++; if (pc !== 32'h300 || if_hold !== 1'b0)
      begin errors++; $display("FAIL bs_run_redirect: got pc=%h if_hold=%b want 300 0", pc, if_hold); end
    stall = 1'b0; halt = 1'b1; br_target = 32'h400;
    step();
    halt = 1'b0; br_taken = 1'b0;
    checks++; if (pc !== 32'h400 || halted !== 1'b0 || im_re !== 1'b1)
      begin errors++; $display("FAIL br_beats_halt: got pc=%h halted=%b im_re=%b want 400 0 1", pc, halted, im_re); end
  endtask

  task automatic test_halt_load();
    halt = 1'b1;
    step();
    halt = 1'b0;
    checks++; if (halted !== 1'b1 || im_re !== 1'b0)
      begin errors++; $display("FAIL halt_enter: got halted=%b im_re=%b want 1 0", halted, im_re); end
    checks++; if (pc !== 32'h400 || if_valid !== 1'b0)
      begin errors++; $display("FAIL halt_pc_valid: got pc=%h if_valid=%b want 400 0", pc, if_valid); end
    run = 1'b1; br_taken = 1'b1; br_target = 32'h500;
    step();
    run = 1'b0; br_taken = 1'b0;
    checks++; if (halted !== 1'b1 || pc !== 32'h400 || flush !== 1'b0)
      begin errors++; $display("FAIL halt_ignores: got halted=%b pc=%h flush=%b want 1 400 0", halted, pc, flush); end
    ld_req = 1'b1;
    step();
    checks++; if (ld_gnt !== 1'b1 || halted !== 1'b0)
      begin errors++; $display("FAIL load_gnt: got ld_gnt=%b halted=%b want 1 0", ld_gnt, halted); end
    step();
    checks++; if (ld_gnt !== 1'b1 || im_re !== 1'b0)
      begin errors++; $display("FAIL load_hold: got ld_gnt=%b im_re=%b want 1 0", ld_gnt, im_re); end
    ld_req = 1'b0;
    step();
    checks++; if (ld_gnt !== 1'b0 || pc !== 32'h0 || im_re !== 1'b0)
      begin errors++; $display("FAIL load_exit: got ld_gnt=%b pc=%h im_re=%b want 0 0 0", ld_gnt, pc, im_re); end
    run = 1'b1;
    step();
    run = 1'b0;
    checks++; if (im_re !== 1'b1) begin errors++; $display("FAIL idle_to_run: got %b want 1", im_re); end
    ld_req = 1'b1;
    step();
    checks++; if (ld_gnt !== 1'b0 || im_re !== 1'b1 || pc !== 32'h4)
      begin errors++; $display("FAIL ld_req_in_run: got ld_gnt=%b im_re=%b pc=%h want 0 1 4", ld_gnt, im_re, pc); end
    ld_req = 1'b0;
  endtask

  task automatic test_wrap();
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    step();
    br_taken = 1'b0;
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h want fffffffc", pc); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", pc); end
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL wrap_next: got %h want 4", pc); end
  endtask

  task automatic test_reset_in_load();
    halt = 1'b1;
    step();
    halt = 1'b0; ld_req = 1'b1;
    step();
    checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL rl_in_load: got %b want 1", ld_gnt); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (ld_gnt !== 1'b0 || halted !== 1'b0 || im_re !== 1'b0)
      begin errors++; $display("FAIL rl_async: got ld_gnt=%b halted=%b im_re=%b want 0 0 0", ld_gnt, halted, im_re); end
    checks++; if (pc !== 32'h0 || flush !== 1'b0 || if_valid !== 1'b0)
      begin errors++; $display("FAIL rl_async_pc: got pc=%h flush=%b if_valid=%b want 0 0 0", pc, flush, if_valid); end
    ld_req = 1'b0;
    #2;
    reset = 1'b1;
    step();
    checks++; if (ld_gnt !== 1'b0 || im_re !== 1'b0)
      begin errors++; $display("FAIL rl_idle: got ld_gnt=%b im_re=%b want 0 0", ld_gnt, im_re); end
    run = 1'b1;
    step();
    run = 1'b0;
    checks++; if (im_re !== 1'b1 || pc !== 32'h0)
      begin errors++; $display("FAIL rl_restart: got im_re=%b pc=%h want 1 0", im_re, pc); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_branch();
    test_stall();
    test_branch_stall();
    test_halt_load();
    test_wrap();
    test_reset_in_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
